// File: rtl/sparce_skip_ctrl.sv
// Sparsity-skip sequencer: SASA table + zero-map; a PC hit with zero sources pulses skipping/sparce_target one cycle later, then holds.
// No backpressure; SPARCE_OR_COND_EN enables the per-entry OR condition (AND-only when undefined).
module sparce_skip_ctrl #(
    parameter int          SASA_ENTRIES = 4,
    parameter logic [31:0] SASA_BASE    = 32'h0000_2000,
    parameter int          HOLD_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic        wb_en,
    input  logic [4:0]  rd,
    input  logic [31:0] wb_data,
    input  logic        sasa_wen,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    output logic        skipping,
    output logic [31:0] sparce_target
);

    localparam int IDX_W = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
`ifdef SPARCE_OR_COND_EN
        logic        cond;
`endif
        logic [11:0] skip_len;
        logic [31:0] trig_pc;
    } sasa_ent_t;

    sasa_ent_t        tbl_q [SASA_ENTRIES];
    sasa_ent_t        tbl_d [SASA_ENTRIES];
    logic [31:0]      zmap_q, zmap_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      trig_pc_q, trig_pc_d;

    logic             win_hit;
    logic             hit;
    logic             hit_cond;
    logic [11:0]      hit_len;
    logic             z1, z2;
    logic             unused_bits;

    always_comb begin
        tbl_d   = tbl_q;
        win_hit = sasa_wen && (sasa_addr[31:8] == SASA_BASE[31:8]);
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            // Upper index bits are dropped, so out-of-range indices alias.
            if (win_hit && (SASA_ENTRIES == 1 || sasa_addr[3 +: IDX_W] == IDX_W'(i))) begin
                if (sasa_addr[2]) begin
                    tbl_d[i].valid    = sasa_data[31];
                    tbl_d[i].rs1      = sasa_data[30:26];
                    tbl_d[i].rs2      = sasa_data[25:21];
`ifdef SPARCE_OR_COND_EN
                    tbl_d[i].cond     = sasa_data[20];
`endif
                    tbl_d[i].skip_len = sasa_data[11:0];
                end else begin
                    tbl_d[i].trig_pc  = {sasa_data[31:2], 2'b00};
                end
            end
        end
    end

    // The next-state zero-map doubles as the forwarded view for lookup.
    always_comb begin
        zmap_d = zmap_q;
        if (wb_en && rd != 5'd0) begin
            zmap_d[rd] = (wb_data == 32'd0);
        end
        zmap_d[0] = 1'b1;
    end

    // Descending scan so the lowest matching index is the one left selected.
    always_comb begin
        hit      = 1'b0;
        hit_cond = 1'b0;
        hit_len  = '0;
        z1       = 1'b0;
        z2       = 1'b0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && tbl_q[i].trig_pc == pc) begin
                z1      = zmap_d[tbl_q[i].rs1];
                z2      = zmap_d[tbl_q[i].rs2];
                hit     = 1'b1;
                hit_len = tbl_q[i].skip_len;
`ifdef SPARCE_OR_COND_EN
                hit_cond = tbl_q[i].cond ? (z1 | z2) : (z1 & z2);
`else
                hit_cond = z1 & z2;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        trig_pc_d = trig_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (hit && hit_cond) begin
                    state_d   = ST_SKIP;
                    target_d  = pc + 32'd4 + {18'd0, hit_len, 2'b00};
                    trig_pc_d = pc;
                    cnt_d     = '0;
                end
            end
            ST_SKIP: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (pc == target_q || cnt_q == CNT_W'(HOLD_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
            zmap_q    <= 32'h0000_0001;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            trig_pc_q <= '0;
        end else begin
            tbl_q     <= tbl_d;
            zmap_q    <= zmap_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            trig_pc_q <= trig_pc_d;
        end
    end

    assign skipping      = (state_q == ST_SKIP);
    assign sparce_target = target_q;

    assign unused_bits = ^{sasa_addr[7:0], sasa_data[20:12], trig_pc_q};

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Directed bench for sparce_skip_ctrl with hand-computed expectations.
module tb_sparce_skip_ctrl;

    logic        CLK;
    logic        nRST;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        sasa_wen;
    logic [31:0] sasa_addr;
    logic [31:0] sasa_data;
    logic        skipping;
    logic [31:0] sparce_target;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] BASE = 32'h0000_2000;

    sparce_skip_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc           (pc),
        .wb_en        (wb_en),
        .rd           (rd),
        .wb_data      (wb_data),
        .sasa_wen     (sasa_wen),
        .sasa_addr    (sasa_addr),
        .sasa_data    (sasa_data),
        .skipping     (skipping),
        .sparce_target(sparce_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
        sasa_wen  = 1'b1;
        sasa_addr = addr;
        sasa_data = data;
        step();
        sasa_wen  = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        rd      = r;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; pc = 32'h0; wb_en = 1'b0; rd = 5'd0; wb_data = 32'h0;
        sasa_wen = 1'b0; sasa_addr = 32'h0; sasa_data = 32'h0;
        step();
        step();
        chk("reset_skipping", {31'd0, skipping}, 32'd0);
        chk("reset_target", sparce_target, 32'h0);
        nRST = 1'b1;

        // entry0: PC 0x100, valid, rs1=5, rs2=0, AND, skip_len=3
        cfg_wr(BASE + 32'h0, 32'h0000_0100);
        cfg_wr(BASE + 32'h4, 32'h9400_0003);
        wb(5'd5, 32'h0);
        pc = 32'h100;
        step();
        chk("basic_pulse", {31'd0, skipping}, 32'd1);
        chk("basic_target", sparce_target, 32'h110);
        step();
        chk("one_cycle_pulse", {31'd0, skipping}, 32'd0);
        chk("target_held", sparce_target, 32'h110);
        step();
        chk("no_retrigger_hold", {31'd0, skipping}, 32'd0);
        pc = 32'h110;
        step();
        pc = 32'h100;
        step();
        chk("rearm_after_target", {31'd0, skipping}, 32'd1);
        pc = 32'h104;
        step();
        pc = 32'h110;
        step();

        // x5 nonzero: no skip
        pc = 32'h0;
        wb(5'd5, 32'h7);
        pc = 32'h100;
        step();
        chk("nonzero_src", {31'd0, skipping}, 32'd0);
        step();
        chk("nonzero_src2", {31'd0, skipping}, 32'd0);

        // same-cycle writeback forwarding
        wb(5'd5, 32'h0);
        chk("fwd_pulse", {31'd0, skipping}, 32'd1);
        chk("fwd_target", sparce_target, 32'h110);

        // HOLD timeout: 16 HOLD cycles, pc=0x100 in the last one must not fire
        pc = 32'h104;
        step();
        for (int i = 0; i < 15; i++) step();
        pc = 32'h100;
        step();
        chk("timeout_not_early", {31'd0, skipping}, 32'd0);
        step();
        chk("timeout_retrigger", {31'd0, skipping}, 32'd1);
        pc = 32'h104;
        step();
        pc = 32'h110;
        step();

        // OR entry in slot 3: PC 0x200, rs1=6, rs2=7, OR, skip_len=2
        pc = 32'h0;
        cfg_wr(BASE + 32'h18, 32'h0000_0200);
        cfg_wr(BASE + 32'h1C, 32'h98F0_0002);
        wb(5'd6, 32'h0);
        wb(5'd7, 32'h1);
        pc = 32'h200;
        step();
`ifdef SPARCE_OR_COND_EN
        chk("or_pulse", {31'd0, skipping}, 32'd1);
        chk("or_target", sparce_target, 32'h20C);
        pc = 32'h204;
        step();
        pc = 32'h20C;
        step();
`else
        chk("or_ignored", {31'd0, skipping}, 32'd0);
`endif

        // out-of-window write must not invalidate entry0
        pc = 32'h0;
        cfg_wr(32'h0000_3004, 32'h0);
        wb(5'd5, 32'h0);
        pc = 32'h100;
        step();
        chk("outside_window", {31'd0, skipping}, 32'd1);
        pc = 32'h104;
        step();
        pc = 32'h110;
        step();

        // priority + wrap: entry1 via aliased address, entry2 direct
        pc = 32'h0;
        cfg_wr(BASE + 32'h28, 32'hFFFF_FFFC);
        cfg_wr(BASE + 32'h2C, 32'h8000_0001);
        cfg_wr(BASE + 32'h10, 32'hFFFF_FFFC);
        cfg_wr(BASE + 32'h14, 32'h8000_0005);
        pc = 32'hFFFF_FFFC;
        step();
        chk("prio_pulse", {31'd0, skipping}, 32'd1);
        chk("prio_wrap_target", sparce_target, 32'h0000_0004);
        nRST = 1'b0;
        step();
        chk("reset_in_skip", {31'd0, skipping}, 32'd0);
        chk("reset_in_skip_tgt", sparce_target, 32'h0);
        nRST = 1'b1;
        step();
        chk("entries_cleared", {31'd0, skipping}, 32'd0);

        // same-cycle config write uses old contents; skip_len=0 target
        pc = 32'h0;
        cfg_wr(BASE + 32'h0, 32'h0000_0100);
        pc = 32'h100;
        cfg_wr(BASE + 32'h4, 32'h8000_0000);
        chk("cfg_old_contents", {31'd0, skipping}, 32'd0);
        step();
        chk("len0_pulse", {31'd0, skipping}, 32'd1);
        chk("len0_target", sparce_target, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
